// File: rtl/event_encoder_8to3.sv
// Eight edge-triggered event lines queued as pending bits and presented one at
// a time as a 3-bit code over a valid/ready handshake, with sticky overflow.
module event_encoder_8to3 #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  input  logic y4,
  input  logic y5,
  input  logic y6,
  input  logic y7,
  input  logic ready,
  input  logic ovf_clr,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic valid,
  output logic ovf,
  output logic busy
);

  logic [7:0] y_vec;
  logic [7:0] y_q;
  logic [7:0] rise_vec;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [7:0] load_mask;
  logic [7:0] ovf_hits;
  logic [2:0] code_q;
  logic [2:0] last_q;
  logic [2:0] sel_idx;
  logic [2:0] cand;
  logic       sel_found;
  logic       valid_q;
  logic       ovf_q;
  logic       out_free;
  logic       load;

  assign y_vec    = {y7, y6, y5, y4, y3, y2, y1, y0};
  assign rise_vec = y_vec & ~y_q;
  assign out_free = ~valid_q | ready;

  // Round-robin scans last+1 .. last+8 (wrapping), so the last-served line is checked last.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    if (ROUND_ROBIN != 0) begin
      for (int k = 1; k <= 8; k++) begin
        cand = last_q + 3'(k);
        if (!sel_found && pending_q[cand]) begin
          sel_idx   = cand;
          sel_found = 1'b1;
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel_idx   = 3'(i);
          sel_found = 1'b1;
        end
      end
    end
  end

  assign load      = out_free & sel_found;
  assign load_mask = load ? (8'b1 << sel_idx) : 8'b0;

  // A new edge on the line being loaded re-arms it; otherwise a repeat edge is lost.
  assign ovf_hits  = rise_vec & pending_q & ~load_mask;
  assign pending_d = (pending_q & ~load_mask) | rise_vec;

  always_ff @(posedge clk) begin
    y_q <= y_vec;
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      ovf_q     <= 1'b0;
      last_q    <= 3'd7;
    end else begin
      pending_q <= pending_d;
      if (out_free) begin
        valid_q <= load;
        if (load) begin
          code_q <= sel_idx;
          last_q <= sel_idx;
        end
      end
      ovf_q <= (|ovf_hits) | (ovf_q & ~ovf_clr);
    end
  end

  assign {s2, s1, s0} = code_q;
  assign valid        = valid_q;
  assign ovf          = ovf_q;
  assign busy         = (|pending_q) | valid_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Drives a fixed-priority and a round-robin encoder with shared stimulus and
// compares both every cycle against an event-queue reference model.
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] y;
  logic       ready;
  logic       ovf_clr;

  logic fp_s2, fp_s1, fp_s0, fp_valid, fp_ovf, fp_busy;
  logic rr_s2, rr_s1, rr_s0, rr_valid, rr_ovf, rr_busy;
  logic [2:0] fp_code;
  logic [2:0] rr_code;

  assign fp_code = {fp_s2, fp_s1, fp_s0};
  assign rr_code = {rr_s2, rr_s1, rr_s0};

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = fixed priority, 1 = round robin.
  logic [7:0] m_yq;
  logic [7:0] m_pend  [2];
  logic       m_valid [2];
  logic [2:0] m_code  [2];
  logic [2:0] m_last  [2];
  logic       m_ovf   [2];

  always #5 clk = ~clk;

  event_encoder_8to3 #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
    .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
    .ready(ready), .ovf_clr(ovf_clr),
    .s2(fp_s2), .s1(fp_s1), .s0(fp_s0),
    .valid(fp_valid), .ovf(fp_ovf), .busy(fp_busy)
  );

  event_encoder_8to3 #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst(rst),
    .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
    .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
    .ready(ready), .ovf_clr(ovf_clr),
    .s2(rr_s2), .s1(rr_s1), .s0(rr_s0),
    .valid(rr_valid), .ovf(rr_ovf), .busy(rr_busy)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Serve order: fixed priority by index; round robin by distance after last.
  task automatic model_step();
    logic [7:0] rises;
    for (int r = 0; r < 2; r++) begin
      if (rst) begin
        m_pend[r]  = '0;
        m_valid[r] = 1'b0;
        m_code[r]  = '0;
        m_ovf[r]   = 1'b0;
        m_last[r]  = 3'd7;
      end else begin
        int  best;
        int  best_d;
        bit  can;
        bit  lost;
        rises  = y & ~m_yq;
        can    = !m_valid[r] || ready;
        best   = -1;
        best_d = 99;
        if (can) begin
          for (int i = 0; i < 8; i++) begin
            if (m_pend[r][i]) begin
              int d;
              d = (r == 1) ? ((i - int'(m_last[r]) + 15) % 8) : i;
              if (d < best_d) begin
                best_d = d;
                best   = i;
              end
            end
          end
        end
        lost = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (rises[i]) begin
            if (m_pend[r][i] && best != i) lost = 1'b1;
            m_pend[r][i] = 1'b1;
          end else if (best == i) begin
            m_pend[r][i] = 1'b0;
          end
        end
        m_ovf[r] = lost ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[r]);
        if (can) begin
          m_valid[r] = (best >= 0);
          if (best >= 0) begin
            m_code[r] = 3'(best);
            m_last[r] = 3'(best);
          end
        end
      end
    end
    m_yq = y;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("fp_valid", int'(fp_valid), int'(m_valid[0]));
    check_val("fp_code",  int'(fp_code),  int'(m_code[0]));
    check_val("fp_ovf",   int'(fp_ovf),   int'(m_ovf[0]));
    check_val("fp_busy",  int'(fp_busy),  int'((m_pend[0] != 0) || m_valid[0]));
    check_val("rr_valid", int'(rr_valid), int'(m_valid[1]));
    check_val("rr_code",  int'(rr_code),  int'(m_code[1]));
    check_val("rr_ovf",   int'(rr_ovf),   int'(m_ovf[1]));
    check_val("rr_busy",  int'(rr_busy),  int'((m_pend[1] != 0) || m_valid[1]));
  endtask

  initial begin
    rst     = 1'b1;
    y       = '0;
    ready   = 1'b0;
    ovf_clr = 1'b0;
    m_yq    = '0;
    for (int r = 0; r < 2; r++) begin
      m_pend[r] = '0; m_valid[r] = 1'b0; m_code[r] = '0; m_last[r] = 3'd7; m_ovf[r] = 1'b0;
    end
    tick();
    tick();
    check_val("rst_valid", int'(fp_valid), 0);
    check_val("rst_code",  int'(fp_code),  0);
    check_val("rst_ovf",   int'(rr_ovf),   0);
    check_val("rst_busy",  int'(rr_busy),  0);
    rst = 1'b0;
    tick();

    // Single event on y3 with ready held high.
    ready = 1'b1;
    y[3]  = 1'b1;
    tick();
    check_val("single_not_yet", int'(fp_valid), 0);
    tick();
    check_val("single_valid", int'(fp_valid), 1);
    check_val("single_code",  int'(fp_code),  3);
    tick();
    check_val("single_drop", int'(fp_valid), 0);
    check_val("single_idle", int'(fp_busy),  0);
    y[3] = 1'b0;
    tick();

    // Fixed-priority burst of y5, y1, y6.
    y[5] = 1'b1; y[1] = 1'b1; y[6] = 1'b1;
    tick();
    tick();
    check_val("burst_c0", int'(fp_code), 1);
    check_val("burst_v0", int'(fp_valid), 1);
    tick();
    check_val("burst_c1", int'(fp_code), 5);
    check_val("burst_v1", int'(fp_valid), 1);
    tick();
    check_val("burst_c2", int'(fp_code), 6);
    check_val("burst_v2", int'(fp_valid), 1);
    tick();
    check_val("burst_end", int'(fp_valid), 0);
    y = '0;
    tick();

    // Round robin after serving index 2, with y1 and y4 pending.
    y[2] = 1'b1;
    tick();
    tick();
    check_val("rr_prev", int'(rr_code), 2);
    y[1] = 1'b1; y[4] = 1'b1;
    tick();
    tick();
    check_val("rr_first",  int'(rr_code), 4);
    check_val("rr_first_v", int'(rr_valid), 1);
    tick();
    check_val("rr_second", int'(rr_code), 1);
    y = '0;
    tick();
    tick();

    // Backpressure: y2 pulses twice while its first event is still queued.
    ready = 1'b0;
    y[0]  = 1'b1;
    tick();
    tick();
    check_val("stall_code", int'(fp_code), 0);
    y[2] = 1'b1; tick();
    y[2] = 1'b0; tick();
    check_val("ovf_quiet", int'(fp_ovf), 0);
    y[2] = 1'b1; tick();
    y[2] = 1'b0; tick();
    check_val("ovf_set_fp", int'(fp_ovf), 1);
    check_val("ovf_set_rr", int'(rr_ovf), 1);
    check_val("stall_hold", int'(fp_code), 0);
    ready = 1'b1;
    tick();
    check_val("ovf_deliver", int'(fp_code), 2);
    tick();
    check_val("ovf_once", int'(fp_valid), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_val("ovf_clr", int'(fp_ovf), 0);
    y = '0;
    tick();

    // Line held high across reset produces no event.
    y[7] = 1'b1;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("held_high", int'(fp_valid | rr_valid), 0);
    end
    y[7] = 1'b0;
    tick();

    // Reset in the middle of a stall with overflow raised.
    ready = 1'b0;
    y[4] = 1'b1; y[5] = 1'b1;
    tick();
    tick();
    y[5] = 1'b0; tick();
    y[5] = 1'b1; tick();
    check_val("pre_rst_valid", int'(fp_valid), 1);
    check_val("pre_rst_ovf",   int'(fp_ovf),   1);
    rst = 1'b1;
    tick();
    check_val("mid_rst_valid", int'(fp_valid), 0);
    check_val("mid_rst_busy",  int'(rr_busy),  0);
    check_val("mid_rst_ovf",   int'(fp_ovf),   0);
    rst = 1'b0;
    y   = '0;
    tick();

    // Randomized traffic: sparse toggles, random backpressure and clears.
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(3) == 0) y[b] = ~y[b];
      ready   = ($urandom_range(9) < 7);
      ovf_clr = ($urandom_range(19) == 0);
      rst     = ($urandom_range(199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
